ray_dispatch: RTL and testbench

RAY_DISPATCH -- requirements
Module: ray_dispatch

---
 rtl/ray_dispatch_pkg.sv | 37 +++
 rtl/ray_dispatch_shade_clamp.sv | 29 ++
 rtl/ray_dispatch.sv | 200 ++++++++++++++++++++
 tb/tb_ray_dispatch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_dispatch_pkg.sv
// Purpose  : shared types and constants for the ray dispatcher and its shade clamp.
// Latency  : n/a (package only).
// Backpres.: n/a (package only).
package ray_dispatch_pkg;

   // Dispatcher FSM states, one per pipeline phase of a single ray.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_MARCH,
      S_CAPTURE,
      S_EMIT
   } state_t;

   // Q8.8 fixed-point unity.
   localparam logic signed [15:0] Q88_ONE = 16'sh0100;

   // Output shade width and pixel-coordinate widths.
   localparam int SHADE_W = 8;
   localparam int PX_W    = 9;
   localparam int PY_W    = 8;
   localparam int ITER_W  = 8;

   // Ray direction component from a pixel offset: (a - b) <<< shift.
   // Both operands are already 16-bit signed, so the subtraction and the
   // shift wrap in 16-bit two's complement with no saturation.
   function automatic logic signed [15:0] dir_from_offset(
      input logic signed [15:0] i_a,
      input logic signed [15:0] i_b,
      input int                 i_shift
   );
      logic signed [15:0] v_diff;
      v_diff = i_a - i_b;
      return v_diff <<< i_shift;
   endfunction

endpackage

// File: rtl/ray_dispatch_shade_clamp.sv
// Purpose  : maps a marcher result (hit, Q8.8 intensity) to an 8-bit shade.
// Latency  : purely combinational.
// Backpres.: none; no handshake on this path.
// Ports    : i_hit, i_intensity (signed Q8.8) in; o_shade out.
module ray_shade_clamp
   import ray_dispatch_pkg::*;
#(
   parameter logic [SHADE_W-1:0] BG_SHADE = 8'h10
)(
   input  logic                     i_hit,
   input  logic signed [15:0]       i_intensity,
   output logic [SHADE_W-1:0]       o_shade
);

   always_comb begin
      o_shade = BG_SHADE;
      if (i_hit) begin
         if (i_intensity < 16'sd0) begin
            o_shade = '0;
         end else if (i_intensity >= Q88_ONE) begin
            o_shade = '1;
         end else begin
            // In [0, 1.0): the fractional byte is the shade directly.
            o_shade = i_intensity[SHADE_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ray_dispatch.sv
// Purpose  : walks a frame in raster order, launches one ray per pixel at the
//            marcher, captures its result and emits a shaded pixel.
// Latency  : MARCH_ITERS + 3 cycles per pixel (LAUNCH..handshake) with pix_ready high.
// Backpres.: pix_valid holds with stable pixel fields until pix_ready; the
//            frame does not advance meanwhile.
// Ports    : clk, rst_n; frame_start, cam_x/y/z in; march_start, ray_org_*,
//            ray_dir_* out to marcher; march_hit, march_intensity in;
//            pix_valid/pix_ready/pix_x/pix_y/pix_shade pixel stream;
//            frame_done pulse; busy.
module ray_dispatch
   import ray_dispatch_pkg::*;
#(
   parameter int                H_PIX       = 160,
   parameter int                V_PIX       = 120,
   parameter int                MARCH_ITERS = 12,
   parameter int                DIR_SHIFT   = 2,
   parameter logic signed [15:0] DIR_Z      = 16'sh0100,
   parameter logic [7:0]        BG_SHADE    = 8'h10
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_start,
   input  logic signed [15:0]   cam_x,
   input  logic signed [15:0]   cam_y,
   input  logic signed [15:0]   cam_z,
   output logic                 march_start,
   output logic signed [15:0]   ray_org_x,
   output logic signed [15:0]   ray_org_y,
   output logic signed [15:0]   ray_org_z,
   output logic signed [15:0]   ray_dir_x,
   output logic signed [15:0]   ray_dir_y,
   output logic signed [15:0]   ray_dir_z,
   input  logic                 march_hit,
   input  logic signed [15:0]   march_intensity,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic [PX_W-1:0]      pix_x,
   output logic [PY_W-1:0]      pix_y,
   output logic [SHADE_W-1:0]   pix_shade,
   output logic                 frame_done,
   output logic                 busy
);

   localparam logic [PX_W-1:0]   L_LAST_PX   = PX_W'(H_PIX - 1);
   localparam logic [PY_W-1:0]   L_LAST_PY   = PY_W'(V_PIX - 1);
   localparam logic [ITER_W-1:0] L_ITER_LOAD = ITER_W'(MARCH_ITERS - 1);
   localparam logic signed [15:0] L_HALF_H   = 16'(H_PIX / 2);
   localparam logic signed [15:0] L_HALF_V   = 16'(V_PIX / 2);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PX_W-1:0]     r_px;
   logic [PY_W-1:0]     r_py;
   logic [ITER_W-1:0]   r_iter;
   logic signed [15:0]  r_org_x, r_org_y, r_org_z;
   logic signed [15:0]  r_dir_x, r_dir_y, r_dir_z;
   logic [SHADE_W-1:0]  r_shade;
   logic                r_frame_done;

   logic                w_org_ld;
   logic                w_pix_ld;
   logic                w_done_set;
   logic                w_last;
   logic [PX_W-1:0]     w_px_nxt;
   logic [PY_W-1:0]     w_py_nxt;
   logic signed [15:0]  w_dir_x_nxt;
   logic signed [15:0]  w_dir_y_nxt;
   logic [SHADE_W-1:0]  w_shade;

   assign w_last = (r_px == L_LAST_PX) && (r_py == L_LAST_PY);

   // Next-state and load enables. A pixel (and its ray direction) is loaded
   // on every entry into LAUNCH, so the direction is already valid while
   // march_start is high.
   always_comb begin
      w_state_nxt = r_state;
      w_org_ld    = 1'b0;
      w_pix_ld    = 1'b0;
      w_done_set  = 1'b0;
      w_px_nxt    = r_px;
      w_py_nxt    = r_py;
      case (r_state)
         S_IDLE: begin
            if (frame_start) begin
               w_org_ld    = 1'b1;
               w_pix_ld    = 1'b1;
               w_px_nxt    = '0;
               w_py_nxt    = '0;
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_state_nxt = S_MARCH;
         end
         S_MARCH: begin
            if (r_iter == '0) begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            if (pix_ready) begin
               if (w_last) begin
                  w_done_set  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_pix_ld    = 1'b1;
                  w_state_nxt = S_LAUNCH;
                  if (r_px == L_LAST_PX) begin
                     w_px_nxt = '0;
                     w_py_nxt = r_py + 8'd1;
                  end else begin
                     w_px_nxt = r_px + 9'd1;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Offsets are formed from zero-extended counters, then sign-carrying
   // subtraction and shift in 16 bits.
   assign w_dir_x_nxt = dir_from_offset($signed({7'b0, w_px_nxt}), L_HALF_H, DIR_SHIFT);
   assign w_dir_y_nxt = dir_from_offset(L_HALF_V, $signed({8'b0, w_py_nxt}), DIR_SHIFT);

   ray_shade_clamp #(
      .BG_SHADE    (BG_SHADE)
   ) u_shade (
      .i_hit       (march_hit),
      .i_intensity (march_intensity),
      .o_shade     (w_shade)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_px         <= '0;
         r_py         <= '0;
         r_iter       <= '0;
         r_org_x      <= '0;
         r_org_y      <= '0;
         r_org_z      <= '0;
         r_dir_x      <= '0;
         r_dir_y      <= '0;
         r_dir_z      <= '0;
         r_shade      <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_done_set;
         if (w_org_ld) begin
            r_org_x <= cam_x;
            r_org_y <= cam_y;
            r_org_z <= cam_z;
         end
         if (w_pix_ld) begin
            r_px    <= w_px_nxt;
            r_py    <= w_py_nxt;
            r_dir_x <= w_dir_x_nxt;
            r_dir_y <= w_dir_y_nxt;
            r_dir_z <= DIR_Z;
         end
         // Counter is primed during LAUNCH so MARCH sees ITERS-1 on entry.
         if (r_state == S_LAUNCH) begin
            r_iter <= L_ITER_LOAD;
         end else if ((r_state == S_MARCH) && (r_iter != '0)) begin
            r_iter <= r_iter - 8'd1;
         end
         if (r_state == S_CAPTURE) begin
            r_shade <= w_shade;
         end
      end
   end

   assign march_start = (r_state == S_LAUNCH);
   assign pix_valid   = (r_state == S_EMIT);
   assign busy        = (r_state != S_IDLE);
   assign frame_done  = r_frame_done;
   assign ray_org_x   = r_org_x;
   assign ray_org_y   = r_org_y;
   assign ray_org_z   = r_org_z;
   assign ray_dir_x   = r_dir_x;
   assign ray_dir_y   = r_dir_y;
   assign ray_dir_z   = r_dir_z;
   assign pix_x       = r_px;
   assign pix_y       = r_py;
   assign pix_shade   = r_shade;

endmodule

// File: tb/tb_ray_dispatch.sv
// Purpose  : self-checking bench for ray_dispatch (small 4x2 frame plus a
//            default-size instance for the first-ray direction).
// Latency  : n/a.
// Backpres.: drives pix_ready randomly and with long stalls.
module tb_ray_dispatch;

   localparam int          H  = 4;
   localparam int          V  = 2;
   localparam int          IT = 3;
   localparam int          SH = 2;
   localparam logic [7:0]  BG = 8'h10;
   localparam logic [15:0] DZ = 16'h0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic [15:0] cam_x, cam_y, cam_z;
   logic        march_start;
   logic [15:0] ray_org_x, ray_org_y, ray_org_z;
   logic [15:0] ray_dir_x, ray_dir_y, ray_dir_z;
   logic        march_hit;
   logic [15:0] march_intensity;
   logic        pix_valid, pix_ready;
   logic [8:0]  pix_x;
   logic [7:0]  pix_y, pix_shade;
   logic        frame_done, busy;

   logic        b_frame_start, b_march_start, b_pix_valid, b_frame_done, b_busy;
   logic [15:0] b_org_x, b_org_y, b_org_z, b_dir_x, b_dir_y, b_dir_z;
   logic [8:0]  b_pix_x;
   logic [7:0]  b_pix_y, b_pix_shade;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_miss = 0;
   logic [15:0] exp_org_x, exp_org_y, exp_org_z;

   ray_dispatch #(
      .H_PIX(H), .V_PIX(V), .MARCH_ITERS(IT), .DIR_SHIFT(SH),
      .DIR_Z(DZ), .BG_SHADE(BG)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
      .march_start(march_start),
      .ray_org_x(ray_org_x), .ray_org_y(ray_org_y), .ray_org_z(ray_org_z),
      .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
      .march_hit(march_hit), .march_intensity(march_intensity),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_shade(pix_shade),
      .frame_done(frame_done), .busy(busy)
   );

   ray_dispatch u_big (
      .clk(clk), .rst_n(rst_n), .frame_start(b_frame_start),
      .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
      .march_start(b_march_start),
      .ray_org_x(b_org_x), .ray_org_y(b_org_y), .ray_org_z(b_org_z),
      .ray_dir_x(b_dir_x), .ray_dir_y(b_dir_y), .ray_dir_z(b_dir_z),
      .march_hit(1'b0), .march_intensity(16'h0000),
      .pix_valid(b_pix_valid), .pix_ready(1'b1),
      .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_shade(b_pix_shade),
      .frame_done(b_frame_done), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: shade from the hit/intensity rules on integers.
   function automatic logic [7:0] ref_shade(input bit hit, input logic [15:0] raw);
      int v;
      v = int'($signed(raw));
      if (!hit) return BG;
      if (v < 0) return 8'd0;
      if (v >= 256) return 8'd255;
      return v[7:0];
   endfunction

   function automatic logic [15:0] exp_dir_x(input int x);
      int v;
      v = (x - H / 2) * (1 << SH);
      return v[15:0];
   endfunction

   function automatic logic [15:0] exp_dir_y(input int y);
      int v;
      v = (V / 2 - y) * (1 << SH);
      return v[15:0];
   endfunction

   task automatic start_frame();
      check("idle_busy", busy, 1'b0);
      cam_x = 16'($urandom); cam_y = 16'($urandom); cam_z = 16'($urandom);
      exp_org_x = cam_x; exp_org_y = cam_y; exp_org_z = cam_z;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      // Origin must stay latched even though the camera keeps moving.
      cam_x = 16'($urandom); cam_y = 16'($urandom); cam_z = 16'($urandom);
   endtask

   task automatic do_pixel(input int x, input int y, input bit hit, input logic [15:0] inten,
                           input int hold, input bit mid_fs, output int hs_cyc);
      int t;
      int lc;
      bit last;
      logic [7:0] shd;
      last = (x == H - 1) && (y == V - 1);
      shd  = ref_shade(hit, inten);
      t = 0;
      while (march_start !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      check("launch_seen", march_start, 1'b1);
      lc = cyc;
      check("dir_x", ray_dir_x, exp_dir_x(x));
      check("dir_y", ray_dir_y, exp_dir_y(y));
      check("dir_z", ray_dir_z, DZ);
      check("org_x", ray_org_x, exp_org_x);
      check("org_y", ray_org_y, exp_org_y);
      check("org_z", ray_org_z, exp_org_z);
      check("busy_launch", busy, 1'b1);
      march_hit = hit;
      march_intensity = inten;
      pix_ready = (hold == 0);
      @(negedge clk);
      check("march_start_pulse", march_start, 1'b0);
      check("dir_x_held", ray_dir_x, exp_dir_x(x));
      if (mid_fs) begin
         frame_start = 1'b1;
         cam_x = 16'($urandom); cam_y = 16'($urandom); cam_z = 16'($urandom);
         @(negedge clk);
         frame_start = 1'b0;
      end
      t = 0;
      while (pix_valid !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      check("valid_latency", 16'(cyc - lc), 16'(IT + 2));
      check("pix_x", 16'(pix_x), 16'(x));
      check("pix_y", 16'(pix_y), 16'(y));
      check("pix_shade", 16'(pix_shade), 16'(shd));
      if (hold > 0) begin
         for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", pix_valid, 1'b1);
            check("hold_x", 16'(pix_x), 16'(x));
            check("hold_y", 16'(pix_y), 16'(y));
            check("hold_shade", 16'(pix_shade), 16'(shd));
         end
         pix_ready = 1'b1;
      end
      hs_cyc = cyc;
      if (hold == 0) check("pixel_latency", 16'(hs_cyc - lc + 1), 16'(IT + 3));
      @(negedge clk);
      check("valid_drop", pix_valid, 1'b0);
      check("frame_done", frame_done, last);
      check("busy_after", busy, !last);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs, prev_hs, t;
      logic [15:0] sweep [5];
      sweep[0] = 16'hFFFB; sweep[1] = 16'h0000; sweep[2] = 16'h00FF;
      sweep[3] = 16'h0100; sweep[4] = 16'h7FFF;

      rst_n = 1'b0; frame_start = 1'b0; b_frame_start = 1'b0;
      cam_x = '0; cam_y = '0; cam_z = '0;
      march_hit = 1'b0; march_intensity = '0; pix_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", pix_valid, 1'b0);
      check("rst_march", march_start, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_dir_x", ray_dir_x, 16'h0000);
      check("rst_org_x", ray_org_x, 16'h0000);
      check("rst_shade", 16'(pix_shade), 16'h0000);
      rst_n = 1'b1;
      @(negedge clk);

      // Default-size instance: first ray direction.
      b_frame_start = 1'b1;
      @(negedge clk);
      b_frame_start = 1'b0;
      check("big_launch", b_march_start, 1'b1);
      check("big_dir_x", b_dir_x, 16'hFEC0);
      check("big_dir_y", b_dir_y, 16'd240);
      check("big_dir_z", b_dir_z, 16'h0100);

      // Frame 1: constant hit at 0.5, ready tied high.
      start_frame();
      prev_hs = -1;
      for (int i = 0; i < H * V; i++) begin
         do_pixel(i % H, i / H, 1'b1, 16'h0080, 0, 1'b0, hs);
         if (prev_hs >= 0) check("hs_spacing", 16'(hs - prev_hs), 16'(IT + 3));
         prev_hs = hs;
      end
      @(negedge clk);
      check("done_pulse_end", frame_done, 1'b0);
      check("idle_no_valid", pix_valid, 1'b0);

      // Frame 2: intensity sweep then misses; long stall; mid-frame restart ignored.
      start_frame();
      for (int i = 0; i < H * V; i++) begin
         if (i < 5)
            do_pixel(i % H, i / H, 1'b1, sweep[i], (i == 2) ? 10 : int'($urandom_range(0, 3)),
                     i == 3, hs);
         else
            do_pixel(i % H, i / H, 1'b0, 16'($urandom), int'($urandom_range(0, 3)), 1'b0, hs);
      end
      @(negedge clk);
      check("done_pulse_end2", frame_done, 1'b0);

      // Frame 3: reset while marching pixel (2,0).
      start_frame();
      do_pixel(0, 0, 1'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0, hs);
      do_pixel(1, 0, 1'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0, hs);
      t = 0;
      while (march_start !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      check("launch_2_0", march_start, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_march", march_start, 1'b0);
      check("arst_valid", pix_valid, 1'b0);
      check("arst_done", frame_done, 1'b0);
      check("arst_pix_x", 16'(pix_x), 16'h0000);
      check("arst_pix_y", 16'(pix_y), 16'h0000);
      check("arst_shade", 16'(pix_shade), 16'h0000);
      check("arst_org_x", ray_org_x, 16'h0000);
      check("arst_org_y", ray_org_y, 16'h0000);
      check("arst_org_z", ray_org_z, 16'h0000);
      check("arst_dir_x", ray_dir_x, 16'h0000);
      check("arst_dir_y", ray_dir_y, 16'h0000);
      check("arst_dir_z", ray_dir_z, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         check("post_rst_valid", pix_valid, 1'b0);
         check("post_rst_busy", busy, 1'b0);
      end

      // Frame 4: fully random frame after reset.
      start_frame();
      for (int i = 0; i < H * V; i++) begin
         do_pixel(i % H, i / H, 1'($urandom), 16'($urandom), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)), hs);
      end
      @(negedge clk);
      check("done_pulse_end4", frame_done, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
